// File: rtl/sigmoid_pkg.sv
// Shared types and constants for the shared LUT-sigmoid datapath.
// Lane formats: Q8.8 signed in, Q0.16 unsigned out.
package sigmoid_pkg;

  localparam int SIG_IN_W    = 16;
  localparam int SIG_OUT_W   = 16;
  localparam int SIG_TILE    = 4;
  localparam int SIG_NUM_REQ = 3;
  localparam int SIG_TAG_DEP = 4;

  typedef logic [SIG_TILE-1:0][SIG_IN_W-1:0]  sig_in_vec_t;
  typedef logic [SIG_TILE-1:0][SIG_OUT_W-1:0] sig_out_vec_t;
  typedef logic [$clog2(SIG_NUM_REQ)-1:0]     req_id_t;

endpackage

// File: rtl/sigmoid_share_arb_tag_fifo.sv
// In-order requester-ID FIFO with first-word fall-through head.
// Depth need not be a power of two; pointers wrap explicitly.
module sig_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rp_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (do_push)
      wp_d = (wp_q == PW'(DEPTH-1)) ? '0 : wp_q + PW'(1);
    if (do_pop)
      rp_d = (rp_q == PW'(DEPTH-1)) ? '0 : rp_q + PW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[wp_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sigmoid_share_arb.sv
// Round-robin share of one in-order 4-lane sigmoid unit among requesters.
// Issue order is kept in a tag FIFO so results route back without reordering.
module sigmoid_share_arb
  import sigmoid_pkg::*;
#(
  parameter int NUM_REQ   = SIG_NUM_REQ,
  parameter int TILE_SIZE = SIG_TILE,
  parameter int IN_W      = SIG_IN_W,
  parameter int OUT_W     = SIG_OUT_W,
  parameter int TAG_DEPTH = SIG_TAG_DEP
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*TILE_SIZE*IN_W-1:0] req_vec,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [TILE_SIZE*OUT_W-1:0]     rsp_vec,
  output logic                           s_in_valid,
  input  logic                           s_in_ready,
  output logic [TILE_SIZE*IN_W-1:0]      s_in_vec,
  input  logic                           s_out_valid,
  output logic                           s_out_ready,
  input  logic [TILE_SIZE*OUT_W-1:0]     s_out_vec,
  output logic [$clog2(TAG_DEPTH+1)-1:0] inflight,
  output logic                           err_underrun
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int VW  = TILE_SIZE * IN_W;
  localparam int CW  = $clog2(TAG_DEPTH+1);

  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] grant, head;
  logic           found;
  logic           tag_full, tag_empty;
  logic           issue, ret;
  logic           err_q, err_d;

  always_comb begin
    int idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = IDW'(idx);
      end
    end
  end

  assign s_in_valid = found && !tag_full;
  assign s_in_vec   = req_vec[int'(grant)*VW +: VW];
  assign issue      = s_in_valid && s_in_ready;

  // Full is evaluated on the registered count only, so a same-cycle
  // pop cannot open the input side combinationally.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = issue && (int'(grant) == i);
      rsp_valid[i] = s_out_valid && !tag_empty && (int'(head) == i);
    end
  end

  assign s_out_ready = !tag_empty && rsp_ready[head];
  assign rsp_vec     = s_out_vec;
  assign ret         = s_out_valid && s_out_ready;

  always_comb begin
    rr_d = rr_q;
    if (issue)
      rr_d = (int'(grant) == NUM_REQ-1) ? '0 : grant + IDW'(1);
    err_d = err_q | (s_out_valid && tag_empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      err_q <= err_d;
    end
  end

  assign err_underrun = err_q;

  sig_tag_fifo #(
    .W     (IDW),
    .DEPTH (TAG_DEPTH),
    .CW    (CW)
  ) u_tags (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (issue),
    .pop   (ret),
    .din   (grant),
    .dout  (head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (inflight)
  );

endmodule
